// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle for uart_tx_fifo: producer write port and transmitter start/data/ready port.
// The slave modport is the FIFO's view; master is the surrounding system (producer + transmitter).
interface uart_tx_fifo_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport slave (
        input  wr_valid, wr_data, tx_ready,
        output wr_ready, tx_start, tx_data
    );

    modport master (
        output wr_valid, wr_data, tx_ready,
        input  wr_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter one byte at a time through its start/data/ready handshake.
// Order is preserved and at most one byte is in flight at the transmitter.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_fifo_if.slave          bus,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count,
    output logic                   idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic          wrAccept;
    logic          pop;

    // Full/empty come from the registered count only; pointers just wrap.
    assign bus.wr_ready = (count != FULL);
    assign wrAccept     = bus.wr_valid && bus.wr_ready;
    assign pop          = (state == IDLE) && (count != '0) && bus.tx_ready;
    assign idle         = (count == '0) && (state == IDLE);

    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrPtr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rdPtr        <= '0;
            wrPtr        <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
        end else begin
            overflow <= bus.wr_valid && !bus.wr_ready;

            if (wrAccept) begin
                wrPtr <= wrPtr + 1'b1;
            end

            case ({wrAccept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // GUARD skips tx_ready: the transmitter only drops it a cycle after sampling start.
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.tx_data  <= mem[rdPtr];
                        rdPtr        <= rdPtr + 1'b1;
                        bus.tx_start <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.tx_start <= 1'b0;
                    state        <= GUARD;
                end
                GUARD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.tx_start <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: transmitter model, scoreboard of expected bytes,
// a table-driven fill/overflow pass and hand-written corner-case sequences.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       overflow;
    logic [4:0] count;
    logic       idle;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .overflow (overflow),
        .count    (count),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    // Transmitter model: 0 = ready held low, 1 = ready tied high,
    // 2 = ready drops one cycle after sampling start and stays low busyLen cycles.
    int   txMode  = 2;
    int   busyLen = 100;
    logic txReady = 1'b0;
    logic seen    = 1'b0;
    int   busy    = 0;
    int   cyc     = 0;

    assign bus.tx_ready = txReady;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        case (txMode)
            0: begin
                txReady <= 1'b0;
                seen    <= 1'b0;
                busy    <= 0;
            end
            1: begin
                txReady <= 1'b1;
                seen    <= 1'b0;
                busy    <= 0;
            end
            default: begin
                if (seen) begin
                    txReady <= 1'b0;
                    busy    <= busyLen;
                    seen    <= 1'b0;
                end else if (busy > 1) begin
                    busy <= busy - 1;
                end else begin
                    busy    <= 0;
                    txReady <= 1'b1;
                end
                if (bus.tx_start) seen <= 1'b1;
            end
        endcase
    end

    int         nChecks = 0;
    int         nFails  = 0;
    logic [7:0] expQ[$];
    int         modelCount   = 0;
    int         startCount   = 0;
    int         lastStartCyc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: every tx_start is checked against the scoreboard and spacing rules.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.tx_start) begin
                check("tx_ready high at tx_start", bus.tx_ready, 1);
                if (startCount > 0) check("tx_start spacing >= 4", (cyc - lastStartCyc) >= 4, 1);
                check("tx_start with byte expected", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    check("tx_data order", bus.tx_data, e);
                end
                if (modelCount > 0) modelCount--;
                lastStartCyc = cyc;
                startCount++;
            end
        end
    end

    // One clock of stimulus, called at negedge+1; checks registered outputs one edge later.
    task automatic cycle(input logic v, input logic [7:0] d);
        logic acc;
        bus.wr_valid = v;
        bus.wr_data  = d;
        check("wr_ready vs occupancy", bus.wr_ready, modelCount != DEPTH);
        acc = v && (modelCount < DEPTH);
        if (acc) begin
            expQ.push_back(d);
            modelCount++;
        end
        @(negedge clk);
        #1;
        check("overflow pulse", overflow, v && !acc);
        check("count", count, modelCount);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (expQ.size() == 0 && idle) break;
            cycle(1'b0, 8'h00);
        end
        check("drain complete", expQ.size(), 0);
        check("idle after drain", idle, 1);
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        int unsigned expCount;
        logic        expOv;
        logic        expWrReady;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int w;
        int r;
        int s0;
        int pushed;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 8'(i), i + 1, 1'b0, (i + 1) < 16};
        end
        vecs[16] = '{1'b1, 8'hFF, 16, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 16, 1'b0, 1'b0};

        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("reset count", count, 0);
        check("reset tx_start", bus.tx_start, 0);
        check("reset tx_data", bus.tx_data, 8'h00);
        check("reset overflow", overflow, 0);
        check("reset wr_ready", bus.wr_ready, 1);
        check("reset idle", idle, 1);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00);

        // Single byte through the busy transmitter model.
        cycle(1'b1, 8'hA5);
        w = cyc;
        check("idle low with byte queued", idle, 0);
        cycle(1'b0, 8'h00);
        check("single byte one pulse", startCount, 1);
        check("single byte pop edge", lastStartCyc, w + 1);
        check("idle low while FSM busy", idle, 0);
        for (int k = 0; k < 300; k++) begin
            if (idle) break;
            cycle(1'b0, 8'h00);
        end
        check("idle returns", idle, 1);
        check("idle return cycle", cyc, w + busyLen + 4);
        check("single byte count back to 0", count, 0);

        // Fill and overflow with the transmitter held busy.
        txMode = 0;
        for (int i = 0; i < 18; i++) begin
            cycle(vecs[i].v, vecs[i].d);
            check("fill count", count, vecs[i].expCount);
            check("fill overflow", overflow, vecs[i].expOv);
            check("fill wr_ready", bus.wr_ready, vecs[i].expWrReady);
        end
        txMode = 1;
        drain(200);

        // Wrap-around with random write gaps and an always-ready transmitter.
        s0 = startCount;
        pushed = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'(i * 7 + 3));
            pushed++;
            repeat ($urandom_range(1, 6)) cycle(1'b0, 8'h00);
        end
        drain(400);
        check("wrap all bytes issued", startCount - s0, pushed);

        // Write on the pop cycle while full: rejected.
        txMode = 0;
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i));
        txMode = 1;
        cycle(1'b0, 8'h00);
        cycle(1'b1, 8'hEE);
        check("full + pop write rejected", overflow, 1);
        check("full + pop count", count, 15);
        drain(200);

        // Write on the pop cycle with one byte queued: accepted, no bypass.
        txMode = 0;
        cycle(1'b1, 8'h40);
        txMode = 1;
        cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h41);
        check("count held at 1", count, 1);
        check("no overflow at count 1", overflow, 0);
        drain(100);

        // Ready honoured: nothing issues while the transmitter is busy.
        txMode = 0;
        cycle(1'b1, 8'h11);
        cycle(1'b1, 8'h22);
        cycle(1'b1, 8'h33);
        s0 = startCount;
        repeat (50) cycle(1'b0, 8'h00);
        check("no tx_start while not ready", startCount, s0);
        txMode = 1;
        r = cyc + 1;
        for (int k = 0; k < 20; k++) begin
            if (startCount != s0) break;
            cycle(1'b0, 8'h00);
        end
        check("first pulse after ready", lastStartCyc, r + 1);
        drain(100);

        // Asynchronous reset with bytes queued and the FSM waiting on a busy transmitter.
        txMode = 2;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC0 + i));
        repeat (4) cycle(1'b0, 8'h00);
        check("queued before reset", count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset count", count, 0);
        check("async reset tx_start", bus.tx_start, 0);
        check("async reset wr_ready", bus.wr_ready, 1);
        check("async reset idle", idle, 1);
        expQ.delete();
        modelCount = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        s0 = startCount;
        repeat (150) cycle(1'b0, 8'h00);
        check("no tx_start after reset", startCount, s0);
        cycle(1'b1, 8'h99);
        drain(300);
        check("new byte issued after reset", startCount, s0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
